mem_access_stage: RTL



---
 rtl/mem_access_stage_pkg.sv | 12 +
 rtl/mem_access_stage_timeout_ctr.sv | 27 ++
 rtl/mem_access_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory access; tc flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + CW'(1);
  end

  assign tc = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues word loads/stores over a req/ready handshake and
// stalls the upstream pipeline until the access completes or times out.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        zero_in,
  input  logic [31:0] C_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  WriteReg_in,
  input  logic [31:0] PCBranch_in,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_READY,
  input  logic [31:0] MEM_RDATA,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] C_out,
  output logic [31:0] ReadData_out,
  output logic [4:0]  WriteReg_out,
  output logic        PCSrc,
  output logic [31:0] PCBranch_out,
  output logic        STALL,
  output logic        TIMEOUT_ERR,
  output logic        ALIGN_ERR
);

  state_t      state;
  logic [31:0] rdata_q;
  logic        wait_tc;
  logic        access;
  logic        misalign;

  assign access   = MemtoReg_in | MemWrite_in;
  assign misalign = access & ((C_in & ~WORD_ALIGN_MASK) != 32'd0);

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (state == S_IDLE),
    .en    (state == S_WAIT),
    .tc    (wait_tc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= 32'd0;
      MEM_WDATA   <= 32'd0;
      rdata_q     <= 32'd0;
      TIMEOUT_ERR <= 1'b0;
      ALIGN_ERR   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            if (misalign) begin
              ALIGN_ERR <= 1'b1;
            end else begin
              state     <= S_WAIT;
              MEM_REQ   <= 1'b1;
              MEM_WE    <= MemWrite_in;
              MEM_ADDR  <= C_in & WORD_ALIGN_MASK;
              MEM_WDATA <= WriteData_in;
            end
          end
        end
        S_WAIT: begin
          // A READY arriving on the terminal cycle still counts as success.
          if (MEM_READY) begin
            if (!MEM_WE)
              rdata_q <= MEM_RDATA;
            MEM_REQ <= 1'b0;
            state   <= S_DONE;
          end else if (wait_tc) begin
            rdata_q     <= ERR_DATA;
            TIMEOUT_ERR <= 1'b1;
            MEM_REQ     <= 1'b0;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // DONE drops the stall for one cycle so MEM_WB captures the result.
  assign STALL = (state == S_WAIT) | ((state == S_IDLE) & access & ~misalign);

  assign RegWrite_out = RegWrite_in & ~STALL & ~(misalign & MemtoReg_in);
  assign MemtoReg_out = MemtoReg_in;
  assign C_out        = C_in;
  assign WriteReg_out = WriteReg_in;
  assign ReadData_out = (state == S_DONE) ? rdata_q : 32'd0;

  assign PCSrc        = Branch_in & zero_in;
  assign PCBranch_out = PCBranch_in;

endmodule
